ball_move_sched: RTL and testbench
==================================

# ball_move_sched

Frame-synchronous move scheduler for the bouncing-ball datapath. It issues per-ball `move` strobes, each at its own programmable frame rate, and applies them only during vertical blanking, after every ball's neighbor scan for the frame is complete. It also runs the game's stop/serve/run sequence, so balls stay frozen until a serve delay has elapsed. It sits between the VGA timing generator (hcount/vcount/pixpulse) and N ball instances.

## Interface
- `NBALLS`, 4, number of ball instances driven.
- `SPEEDW`, 4, width of each per-ball speed field.
- `FRAME_LINE`, 480, vcount value that marks the frame boundary (first blanking line).
- `SERVE_FRAMES`, 60, frames to wait in SERVE before the first move. Legal range 1..65535.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pixpulse` in 1: 25 MHz pixel enable, high one clk in four.
- `hcount` in 10: current pixel x.
- `vcount` in 10: current pixel y.
- `run` in 1: level; 1 = play, 0 = stop.
- `speed` in NBALLS*SPEEDW: field i, bits [i*SPEEDW +: SPEEDW], is frames per step for ball i. 0 disables ball i.
- `move` out NBALLS: per-ball move strobe, wired to each ball's `move` input.
- `frame_tick` out 1: one-clk pulse per frame boundary, in every state.
- `state` out 2: 00 STOP, 01 SERVE, 10 RUN.
- `frame_count` out 16: frames elapsed in RUN.

## Operation
- Frame event E = `pixpulse` & `hcount`==0 & `vcount`==FRAME_LINE, evaluated on the clk edge.
- FSM transitions:
  - STOP → SERVE: when `run`=1. On entry, clear `serve_cnt`, all `cnt_i`, and `frame_count`.
  - SERVE: at each E, `serve_cnt`++. At the E where `serve_cnt`==SERVE_FRAMES-1, go to RUN. No move is issued on that frame.
  - RUN: stays in RUN while `run`=1.
  - Any state → STOP: when `run`=0, checked before all other transitions. The clk edge that enters STOP also clears every pending `move`.
- Per-ball divider `cnt_i` (SPEEDW bits), at each E in RUN:
  - If `speed_i`==0: `cnt_i` held at 0, no move.
  - Else if `cnt_i` >= `speed_i`-1: `cnt_i`←0 and set pending `move[i]`.
  - Else: `cnt_i`++.
  - The comparison is >=, so lowering `speed_i` takes effect at the next E with no wrap-through.
- `move[i]` is a register. It is set at E and cleared at the next clk edge with `pixpulse`=1. A ball therefore sees exactly one pixpulse-qualified cycle with `move` high per step.
- `frame_count` increments at each E in RUN and wraps from 0xFFFF to 0.
- Reset values: `state`=STOP; `move`, `frame_tick`, `frame_count`, all `cnt_i`, and `serve_cnt` = 0.

## Timing
- E at edge k (a pixpulse clk) drives `frame_tick`=1 during cycle k+1 only.
- `move[i]` is high for cycles k+1..k+4. It is cleared at the edge ending cycle k+4, the next pixpulse clk, so each set `move[i]` is high for 4 clks.
- Latency from E to `move` is 1 clk. All strobed balls receive `move` simultaneously.
- `run`=0 at edge j: `state`=STOP and `move`=0 from cycle j+1. If this happens before the pixpulse clk, the ball does not step.
- `run`=1 in STOP at edge j: `state`=SERVE from cycle j+1.
- `run` toggling 1→0→1 between two E events restarts SERVE from 0.
- E on the same edge as the SERVE → RUN transition does no divider update. The divider starts at the next E.
- `speed` is sampled only at E. Changes between E events have no effect.
- `rst` asserted mid-strobe clears `move` asynchronously.

## Test plan
Bench parameters: NBALLS=2, SPEEDW=4, FRAME_LINE=5, SERVE_FRAMES=2. The bench drives `hcount`/`vcount` directly.

- Reset with `run`=0 → `state`=00, `move`=00, `frame_count`=0. `frame_tick` pulses once per E with no `move`.
- `run`=1, speed={1,1} → SERVE for 2 E events, RUN after the 2nd. `move`=11 on every E from the 3rd, each high exactly 4 clks, and `frame_count`=1 after the 3rd.
- speed={3,0} (ball1=3, ball0=0) in RUN → `move[1]` on every 3rd E, `move[0]` never set.
- Speed 7→2 with `cnt_1`=4 → at the next E, `cnt_1`>=1, so `move[1]` fires and `cnt_1`=0.
- `run`→0 one clk after E → `move` cleared before the next pixpulse, `state`=00, no pixpulse clk sees `move`=1.
- Force `frame_count`=0xFFFF via 65535 frames in RUN → the next E wraps it to 0. `rst` pulse mid-strobe → all outputs 0 immediately.

Source files
------------

// File: rtl/ball_move_sched.sv
// Frame-synchronous move scheduler: per-ball frame-rate dividers gated by a
// stop/serve/run sequence, with move strobes issued at the frame boundary.
module ball_move_sched #(
  parameter int NBALLS       = 4,
  parameter int SPEEDW       = 4,
  parameter int FRAME_LINE   = 480,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pixpulse,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     run,
  input  logic [NBALLS*SPEEDW-1:0] speed,
  output logic [NBALLS-1:0]        move,
  output logic                     frame_tick,
  output logic [1:0]               state,
  output logic [15:0]              frame_count
);

  localparam logic [9:0]  FRAME_V    = 10'(FRAME_LINE);
  localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_SERVE = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  state_t              cur_state;
  state_t              next_state;
  logic                frame_e;
  logic                enter_serve;
  logic                serve_step;
  logic                run_step;
  logic [15:0]         serve_cnt;
  logic [NBALLS-1:0]   fire_vec;

  assign frame_e = pixpulse && (hcount == 10'd0) && (vcount == FRAME_V);
  assign state   = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= ST_STOP;
    else     cur_state <= next_state;
  end

  // Dropping run overrides every other transition.
  always_comb begin
    next_state = cur_state;
    if (!run) begin
      next_state = ST_STOP;
    end else begin
      case (cur_state)
        ST_STOP:  next_state = ST_SERVE;
        ST_SERVE: if (frame_e && (serve_cnt == SERVE_LAST)) next_state = ST_RUN;
        ST_RUN:   next_state = ST_RUN;
        default:  next_state = ST_STOP;
      endcase
    end
  end

  always_comb begin
    enter_serve = 1'b0;
    serve_step  = 1'b0;
    run_step    = 1'b0;
    case (cur_state)
      ST_STOP:  enter_serve = run;
      ST_SERVE: serve_step  = run & frame_e;
      ST_RUN:   run_step    = run & frame_e;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              serve_cnt <= 16'd0;
    else if (enter_serve) serve_cnt <= 16'd0;
    else if (serve_step)  serve_cnt <= serve_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              frame_count <= 16'd0;
    else if (enter_serve) frame_count <= 16'd0;
    else if (run_step)    frame_count <= frame_count + 16'd1;
  end

  for (genvar i = 0; i < NBALLS; i++) begin : g_ball
    logic [SPEEDW-1:0] spd;
    logic [SPEEDW-1:0] cnt;
    logic [SPEEDW-1:0] cnt_next;
    logic              fire;

    assign spd = speed[i*SPEEDW +: SPEEDW];

    // >= rather than == so a lowered speed fires at once instead of wrapping.
    always_comb begin
      fire     = 1'b0;
      cnt_next = cnt;
      if (spd == '0) begin
        cnt_next = '0;
      end else if (cnt >= spd - 1'b1) begin
        cnt_next = '0;
        fire     = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (enter_serve) cnt <= '0;
      else if (run_step)    cnt <= cnt_next;
    end

    assign fire_vec[i] = fire;
  end

  // A set strobe survives until the next pixel-enabled edge, so each ball
  // samples it on exactly one pixpulse cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           move <= '0;
    else if (!run)     move <= '0;
    else if (run_step) move <= fire_vec;
    else if (pixpulse) move <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= frame_e;
  end

endmodule

// File: tb/tb_ball_move_sched.sv
// Self-checking bench for ball_move_sched: directed scenarios plus randomized
// traffic compared against a frame-level behavioural model.
module tb_ball_move_sched;

  localparam int NB = 2;
  localparam int SW = 4;
  localparam int FL = 5;
  localparam int SF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixpulse;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        run;
  logic [7:0]  speed;
  logic [1:0]  move;
  logic        frame_tick;
  logic [1:0]  state;
  logic [15:0] frame_count;

  ball_move_sched #(
    .NBALLS(NB), .SPEEDW(SW), .FRAME_LINE(FL), .SERVE_FRAMES(SF)
  ) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount),
    .vcount(vcount), .run(run), .speed(speed), .move(move),
    .frame_tick(frame_tick), .state(state), .frame_count(frame_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  // ---------------- reference model ----------------
  int         m_state;
  int         m_serve;
  int         m_fc;
  int         m_cnt[NB];
  logic [1:0] m_move;
  logic       m_tick;

  task automatic model_reset();
    m_state = 0; m_serve = 0; m_fc = 0;
    for (int b = 0; b < NB; b++) m_cnt[b] = 0;
    m_move = 2'b00; m_tick = 1'b0;
  endtask

  task automatic model_step();
    bit         e;
    int         sp;
    logic [1:0] fire;
    e = pixpulse && (hcount == 10'd0) && (vcount == 10'(FL));
    m_tick = e;
    if (!run) begin
      m_state = 0;
      m_move  = 2'b00;
    end else if (m_state == 0) begin
      m_state = 1; m_serve = 0; m_fc = 0;
      for (int b = 0; b < NB; b++) m_cnt[b] = 0;
    end else if (m_state == 1) begin
      if (e) begin
        if (m_serve == SF - 1) m_state = 2;
        else m_serve++;
      end
      if (pixpulse) m_move = 2'b00;
    end else begin
      if (e) begin
        m_fc = (m_fc + 1) % 65536;
        fire = 2'b00;
        for (int b = 0; b < NB; b++) begin
          sp = int'(speed[b*SW +: SW]);
          if (sp == 0) m_cnt[b] = 0;
          else if (m_cnt[b] >= sp - 1) begin m_cnt[b] = 0; fire[b] = 1'b1; end
          else m_cnt[b]++;
        end
        m_move = fire;
      end else if (pixpulse) begin
        m_move = 2'b00;
      end
    end
  endtask

  // ---------------- driver ----------------
  int phase      = 0;
  bit pix_always = 1'b0;
  bit frame_on   = 1'b1;

  task automatic set_inputs();
    pixpulse = pix_always || (phase == 3);
    if (pixpulse && frame_on) begin
      hcount = 10'd0; vcount = 10'(FL);
    end else if (!pixpulse && $urandom_range(0, 3) == 0) begin
      hcount = 10'd0; vcount = 10'(FL);
    end else begin
      hcount = 10'($urandom_range(1, 799));
      vcount = 10'($urandom_range(0, 524));
    end
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    set_inputs();
  endtask

  task automatic run_to_e();
    int n;
    n = 0;
    do begin tick(); n++; end while (!m_tick && n < 50);
    if (!m_tick) begin
      n_cmp++; n_fail++;
      $display("FAIL e_timeout: no frame event within %0d cycles", n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; run = 1'b0; speed = 8'h00;
    set_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({state, move, frame_count, frame_tick} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_vals: got st=%b mv=%b fc=%h tk=%b want all 0",
               state, move, frame_count, frame_tick);
    end
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 40; c++) begin
      frame_on = ($urandom_range(0, 1) == 1);
      tick();
      n_cmp++;
      if ({state, move, frame_tick} !== {2'b00, 2'b00, m_tick}) begin
        n_fail++;
        $display("FAIL stop_tick c=%0d: got st=%b mv=%b tk=%b want st=00 mv=00 tk=%b",
                 c, state, move, frame_tick, m_tick);
      end
    end
    frame_on = 1'b1;
  endtask

  task automatic test_serve();
    int hi;
    speed = {4'd1, 4'd1};
    run = 1'b1;
    tick();
    n_cmp++;
    if (state !== 2'b01) begin n_fail++; $display("FAIL serve_entry: got %b want 01", state); end
    run_to_e();
    n_cmp++;
    if (state !== 2'b01) begin n_fail++; $display("FAIL serve_e1: got %b want 01", state); end
    run_to_e();
    n_cmp++;
    if ({state, move} !== 4'b1000) begin
      n_fail++; $display("FAIL serve_e2: got st=%b mv=%b want st=10 mv=00", state, move);
    end
    run_to_e();
    n_cmp++;
    if ({move, frame_count} !== {2'b11, 16'd1}) begin
      n_fail++; $display("FAIL run_e3: got mv=%b fc=%0d want mv=11 fc=1", move, frame_count);
    end
    frame_on = 1'b0;
    hi = 1;
    repeat (7) begin tick(); if (move === 2'b11) hi++; end
    n_cmp++;
    if (hi != 4) begin n_fail++; $display("FAIL move_width: got %0d clks want 4", hi); end
    frame_on = 1'b1;
  endtask

  task automatic test_divider();
    logic [1:0] e;
    speed = {4'd3, 4'd0};
    for (int f = 0; f < 9; f++) exp_q.push_back((f % 3 == 2) ? 2'b10 : 2'b00);
    for (int f = 0; f < 9; f++) begin
      run_to_e();
      e = exp_q.pop_front();
      n_cmp++;
      if (move !== e) begin n_fail++; $display("FAIL divider f=%0d: got %b want %b", f, move, e); end
    end
  endtask

  task automatic test_speed_drop();
    run = 1'b0;
    tick();
    n_cmp++;
    if ({state, move} !== 4'b0000) begin
      n_fail++; $display("FAIL drop_stop: got st=%b mv=%b want 00/00", state, move);
    end
    run = 1'b1;
    speed = {4'd7, 4'd0};
    tick();
    repeat (2) run_to_e();
    repeat (4) run_to_e();
    if (m_cnt[1] != 4) begin
      n_cmp++; n_fail++; $display("FAIL drop_setup: model cnt1=%0d want 4", m_cnt[1]);
    end
    speed = {4'd2, 4'd0};
    run_to_e();
    n_cmp++;
    if (move !== 2'b10) begin n_fail++; $display("FAIL drop_fire: got %b want 10", move); end
    run_to_e();
    n_cmp++;
    if (move !== 2'b00) begin n_fail++; $display("FAIL drop_next: got %b want 00", move); end
    run_to_e();
    n_cmp++;
    if (move !== 2'b10) begin n_fail++; $display("FAIL drop_again: got %b want 10", move); end
  endtask

  task automatic test_stop_mid();
    speed = {4'd1, 4'd1};
    run_to_e();
    n_cmp++;
    if (move !== 2'b11) begin n_fail++; $display("FAIL stop_pre: got %b want 11", move); end
    run = 1'b0;
    tick();
    n_cmp++;
    if ({state, move} !== 4'b0000) begin
      n_fail++; $display("FAIL stop_now: got st=%b mv=%b want 00/00", state, move);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (move !== 2'b00) begin
        n_fail++; $display("FAIL stop_hold c=%0d pix=%b: got %b want 00", c, pixpulse, move);
      end
    end
    run = 1'b1;
    tick();
    run_to_e();
    n_cmp++;
    if (state !== 2'b01) begin n_fail++; $display("FAIL reserve_e1: got %b want 01", state); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) speed = 8'($urandom);
      if (run && $urandom_range(0, 99) == 0) run = 1'b0;
      else if (!run && $urandom_range(0, 3) == 0) run = 1'b1;
      frame_on = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if ({state, move, frame_count, frame_tick} !==
          {2'(m_state), m_move, 16'(m_fc), m_tick}) begin
        n_fail++;
        $display("FAIL random c=%0d: got st=%b mv=%b fc=%0d tk=%b want st=%0d mv=%b fc=%0d tk=%b",
                 c, state, move, frame_count, frame_tick, m_state, m_move, m_fc, m_tick);
      end
    end
    frame_on = 1'b1;
    run = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    run = 1'b0;
    tick();
    run = 1'b1;
    speed = 8'h21;
    pix_always = 1'b1;
    frame_on = 1'b1;
    n = 0;
    do begin tick(); n++; end while (m_state != 2 && n < 20);
    repeat (65535) tick();
    n_cmp++;
    if (frame_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_max: got %h want ffff", frame_count);
    end
    tick();
    n_cmp++;
    if (frame_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero: got %h want 0000", frame_count);
    end
    pix_always = 1'b0;
  endtask

  task automatic test_reset_mid();
    speed = 8'h11;
    frame_on = 1'b1;
    run_to_e();
    run_to_e();
    n_cmp++;
    if (move !== 2'b11) begin n_fail++; $display("FAIL rst_pre: got %b want 11", move); end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({state, move, frame_count, frame_tick} !== 21'd0) begin
      n_fail++;
      $display("FAIL rst_async: got st=%b mv=%b fc=%h tk=%b want all 0",
               state, move, frame_count, frame_tick);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (state !== 2'b01) begin n_fail++; $display("FAIL rst_resume: got %b want 01", state); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_divider();
    test_speed_drop();
    test_stop_mid();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
